sin_lookup_arbiter: RTL and testbench
=====================================

# sin_lookup_arbiter

Round-robin arbiter and response pipeline that shares one `sintable` lookup ROM among up to `NUM_REQ` requesters, such as ball-trajectory, sound and animation blocks. Each requester issues an address with a req/gnt handshake. The block steers the winning address to the ROM, tracks the in-flight lookup by requester ID and returns the 16-bit sign-extended table value with a one-cycle valid strobe to the originating requester. Throughput is one lookup per clock.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `COUNT_SIZE`, default 8: ROM address width. Must match the shared `sintable` instance.

Ports:
- `clk`, in, 1: system clock.
- `resetN`, in, 1: reset. One clock; reset is synchronous and active-low.
- `req`, in, `NUM_REQ`: per-requester request level.
- `addr`, in, `NUM_REQ` x `COUNT_SIZE`: per-requester table address.
- `gnt`, out, `NUM_REQ`: one-hot grant. The address is consumed in the cycle `gnt` is high.
- `rom_addr`, out, `COUNT_SIZE`: connects to `sintable.ADDR`.
- `rom_q`, in, 16: connects to `sintable.Q`. Valid one cycle after `rom_addr` is driven.
- `rsp_valid`, out, `NUM_REQ`: one-hot response strobe, one cycle wide.
- `rsp_data`, out, 16: sign-extended table value, valid while any `rsp_valid` bit is high.

## Operation
- **Arbitration:** combinational on `req` and the round-robin pointer `rr_ptr`.
  - The search starts at `rr_ptr` and wraps modulo `NUM_REQ`. The first set `req` bit wins.
  - In the same cycle, the block drives `gnt[w]`=1 and `rom_addr`=`addr[w]`.
- **Pointer update:** on a grant, `rr_ptr` <= (w+1) mod `NUM_REQ`. With no request, `rr_ptr` holds.
- **Requester rules:**
  - Hold `req` and `addr` stable until `gnt` is seen.
  - Drop `req` the cycle after the grant, or keep it high for a back-to-back lookup with a new `addr`.
  - A requester may hold `req` continuously. It is granted at most once every `NUM_REQ` cycles when all requesters are active.
- **Tag pipeline:** two stages, each holding {valid, id}.
  - Stage 1 loads {grant_any, w}.
  - Stage 2 loads stage 1.
- **Response capture:** when stage 1 is valid, `rsp_data` <= `rom_q`.
  - `rsp_valid[id2]` is high when stage 2 is valid.
  - `rsp_data` holds its last value when no response is issued.
- **Idle cycles:** with no `req`, `gnt`=0 and `rom_addr` holds its previous value (registered copy). No tag is inserted.
- **Data path:** data passes through unmodified. Sign extension is already done by the ROM.
- **Simultaneous events:**
  - A new grant, a capture and a response strobe can all occur in the same cycle, possibly to the same requester.
  - A requester may receive a response in the cycle it is re-granted.
- **Reset mid-operation:** all in-flight tags are discarded and no `rsp_valid` is issued for them. `gnt` is forced to 0 while `resetN`=0.

## Timing
- **Reset values:**
  - `gnt`=0, `rsp_valid`=0, `rsp_data`=16'h0000.
  - `rom_addr`=0, `rr_ptr`=0 (requester 0 has top priority), both tag stages invalid.
- **Cycle sequence:**
  - Grant in cycle t.
  - ROM registers `rom_addr` at the end of t.
  - `rom_q` is valid in t+1 and is captured at the end of t+1.
  - `rsp_valid` is high in t+2.
  - Latency is 2 cycles from grant to response.
- **Throughput:** one grant and one response per cycle, sustained. No backpressure on responses; requesters must accept the strobe.
- **Critical path:** the combinational path from `req` through the priority picker to `rom_addr` mux and `gnt`. It must close at 50 MHz for `NUM_REQ`=8.

## Structure
- **Package `sin_arb_pkg`:**
  - `DATA_W`=16.
  - `RSP_LATENCY`=2.
  - `typedef struct packed {logic valid; logic [2:0] id;} sin_tag_t`.
- **Sub-module `rr_priority_picker`:**
  - Parameter `N`.
  - Inputs `req`, `ptr`.
  - Outputs `onehot`, `idx`, `any`.
  - Purely combinational; reused by other shared-resource arbiters.
- **Top-level contents:** the pointer register, the address mux/hold register, the tag pipeline and the response register.

## Test plan
- **Single requester:** `req[0]` with `addr`=1 for one cycle -> `gnt[0]` in t, `rsp_valid[0]` in t+2 with `rsp_data`=16'h0006.
- **Three concurrent requesters:** `req[0..2]` all high from reset with `addr` 0, 32, 64 -> grants 0, 1, 2 in consecutive cycles. Responses arrive in consecutive cycles: 0: 16'h0000, 1: 16'hFFB5, 2: 16'hFFFF.
- **Fairness:** all four `req` held high for 12 cycles -> grant sequence 0,1,2,3 repeated three times. Each requester receives exactly 3 responses.
- **Pointer wrap:** grant `req[3]`, then `req[0]` and `req[3]` both high -> `req[0]` is granted first. `addr`=128 returns 16'h0000.
- **Reset mid-flight:** `resetN` is low in the cycle after a grant to requester 2 -> no `rsp_valid` is ever seen for that lookup. All outputs are at reset values the next cycle, and `rr_ptr` returns to 0.
- **Idle hold:** `req`=0 for 5 cycles after a lookup of `addr`=32 -> `rom_addr` stays 32, `rsp_valid` stays 0, `rsp_data` holds 16'hFFB5.

Source files
------------

// File: rtl/sin_lookup_arbiter_pkg.sv
// Shared types and constants for the sintable lookup arbiter.
package sin_arb_pkg;

  localparam int DATA_W      = 16;
  localparam int RSP_LATENCY = 2;

  // One in-flight lookup: valid flag plus the requester it belongs to.
  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } sin_tag_t;

  localparam sin_tag_t TAG_IDLE = '{valid: 1'b0, id: 3'd0};

  // Width of a requester index; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sin_lookup_arbiter_if.sv
// Requester-side bundle: request/grant handshake plus response strobe and data.
interface sin_lookup_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int COUNT_SIZE = 8
);
  import sin_arb_pkg::*;

  logic [NUM_REQ-1:0]                 req;
  logic [NUM_REQ-1:0][COUNT_SIZE-1:0] addr;
  logic [NUM_REQ-1:0]                 gnt;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [DATA_W-1:0]                  rsp_data;

  // Requesters drive req/addr and observe grant and response.
  modport master (
    output req,
    output addr,
    input  gnt,
    input  rsp_valid,
    input  rsp_data
  );

  // The arbiter consumes req/addr and produces grant and response.
  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/sin_lookup_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_priority_picker #(
  parameter  int N  = 4,
  localparam int IW = (N > 2) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam int            SW  = IW + 1;
  localparam logic [SW-1:0] N_W = SW'(N);

  logic [SW-1:0] cand_s;

  // Walk offsets from farthest to nearest so the requester closest to ptr overrides the rest.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand_s = {1'b0, ptr} + SW'(off);
      if (cand_s >= N_W) begin
        cand_s = cand_s - N_W;
      end else begin
        cand_s = cand_s;
      end
      if (req[cand_s[IW-1:0]]) begin
        onehot                 = '0;
        onehot[cand_s[IW-1:0]] = 1'b1;
        idx                    = cand_s[IW-1:0];
        any                    = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/sin_lookup_arbiter.sv
// Round-robin sharing of one sintable ROM among NUM_REQ requesters, with a
// two-stage tag pipeline that routes each ROM result back to its requester.
module sin_lookup_arbiter
  import sin_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int COUNT_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  sin_lookup_arbiter_if.slave   bus,
  output logic [COUNT_SIZE-1:0] rom_addr,
  input  logic [DATA_W-1:0]     rom_q
);

  localparam int               PTR_W    = ptr_width(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]      rr_ptr_r;
  logic [PTR_W-1:0]      win_idx_s;
  logic [PTR_W-1:0]      ptr_next_s;
  logic [NUM_REQ-1:0]    win_onehot_s;
  logic [NUM_REQ-1:0]    gnt_s;
  logic [NUM_REQ-1:0]    rsp_valid_s;
  logic                  pick_any_s;
  logic                  grant_any_s;
  logic [COUNT_SIZE-1:0] rom_addr_r;
  logic [COUNT_SIZE-1:0] rom_addr_s;
  sin_tag_t              tag1_next_s;
  sin_tag_t              tag1_r;
  sin_tag_t              tag2_r;
  logic [DATA_W-1:0]     rsp_data_r;

  rr_priority_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req    (bus.req),
    .ptr    (rr_ptr_r),
    .onehot (win_onehot_s),
    .idx    (win_idx_s),
    .any    (pick_any_s)
  );

  // Grant decode, ROM address steering and next pointer; no grant is issued while in reset.
  always_comb begin
    grant_any_s = pick_any_s & resetN;
    if (grant_any_s) begin
      gnt_s       = win_onehot_s;
      rom_addr_s  = bus.addr[win_idx_s];
      ptr_next_s  = (win_idx_s == LAST_IDX) ? {PTR_W{1'b0}} : (win_idx_s + PTR_W'(1));
      tag1_next_s = '{valid: 1'b1, id: 3'(win_idx_s)};
    end else begin
      gnt_s       = '0;
      rom_addr_s  = rom_addr_r;
      ptr_next_s  = rr_ptr_r;
      tag1_next_s = TAG_IDLE;
    end
  end

  // Pointer, idle address hold, tag pipeline and response data capture.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      rr_ptr_r   <= '0;
      rom_addr_r <= '0;
      tag1_r     <= TAG_IDLE;
      tag2_r     <= TAG_IDLE;
      rsp_data_r <= {DATA_W{1'b0}};
    end else begin
      rr_ptr_r   <= ptr_next_s;
      rom_addr_r <= rom_addr_s;
      tag1_r     <= tag1_next_s;
      tag2_r     <= tag1_r;
      if (tag1_r.valid) begin
        rsp_data_r <= rom_q;
      end else begin
        rsp_data_r <= rsp_data_r;
      end
    end
  end

  // Response strobe is a straight decode of the stage-2 tag register.
  always_comb begin
    rsp_valid_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag2_r.valid && (tag2_r.id == 3'(i))) begin
        rsp_valid_s[i] = 1'b1;
      end else begin
        rsp_valid_s[i] = 1'b0;
      end
    end
  end

  assign bus.gnt       = gnt_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_data  = rsp_data_r;
  assign rom_addr      = rom_addr_s;

endmodule

// File: tb/tb_sin_lookup_arbiter.sv
// Self-checking bench: ROM model, round-robin reference and response scoreboard.
module tb_sin_lookup_arbiter;
  import sin_arb_pkg::*;

  localparam int NR = 4;
  localparam int CS = 8;

  typedef struct {
    int          due;
    int          id;
    logic [15:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetN;
  logic [CS-1:0] rom_addr;
  logic [15:0]   rom_q;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   mptr         = 0;
  bit   mon_en       = 1'b0;
  int   rsp_seen [NR];
  exp_t sb [$];

  sin_lookup_arbiter_if #(.NUM_REQ(NR), .COUNT_SIZE(CS)) bus ();

  sin_lookup_arbiter #(.NUM_REQ(NR), .COUNT_SIZE(CS)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_q    (rom_q)
  );

  always #5 clk = ~clk;

  // Reference sintable contents for the addresses the scenarios use.
  function automatic logic [15:0] rom_fn(input logic [CS-1:0] a);
    case (a)
      8'd0:    return 16'h0000;
      8'd1:    return 16'h0006;
      8'd32:   return 16'hFFB5;
      8'd64:   return 16'hFFFF;
      8'd128:  return 16'h0000;
      default: return {8'hA5, a};
    endcase
  endfunction

  // Synchronous ROM: address registered at the clock edge.
  always @(posedge clk) rom_q <= rom_fn(rom_addr);

  // Cycle counter used to time expected responses.
  always @(posedge clk) cyc <= cyc + 1;

  // Response checker: every cycle either the due scoreboard entry or silence.
  task automatic monitor();
    exp_t            e;
    logic [NR-1:0]   ev;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < NR; i++) if (bus.rsp_valid[i]) rsp_seen[i]++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          ev = '0;
          ev[e.id] = 1'b1;
          tests_run++;
          if (bus.rsp_valid !== ev || bus.rsp_data !== e.data) begin
            tests_failed++;
            $display("FAIL rsp cyc=%0d: got valid=%b data=%h, want valid=%b data=%h",
                     cyc, bus.rsp_valid, bus.rsp_data, ev, e.data);
          end
        end else begin
          tests_run++;
          if (bus.rsp_valid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rsp_quiet cyc=%0d: got valid=%b, want 0000", cyc, bus.rsp_valid);
          end
        end
      end
    end
  endtask

  // Drive one cycle, predict the winner, queue its response, sample grant side at negedge.
  task automatic step(input logic [NR-1:0] r, input logic [NR-1:0][CS-1:0] a,
                      output logic [NR-1:0] g, output logic [CS-1:0] ra, output logic [15:0] rd);
    int   w;
    exp_t e;
    bus.req  = r;
    bus.addr = a;
    w = -1;
    for (int k = 0; k < NR; k++) begin
      if (w < 0 && r[(mptr + k) % NR]) w = (mptr + k) % NR;
    end
    @(negedge clk);
    g  = bus.gnt;
    ra = rom_addr;
    rd = bus.rsp_data;
    if (w >= 0) begin
      e.due  = cyc + RSP_LATENCY;
      e.id   = w;
      e.data = rom_fn(a[w]);
      sb.push_back(e);
      mptr = (w + 1) % NR;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic [NR-1:0] g;
    logic [CS-1:0] ra;
    logic [15:0]   rd;
    for (int i = 0; i < n; i++) step('0, '0, g, ra, rd);
  endtask

  task automatic do_reset();
    bus.req = '0;
    resetN  = 1'b0;
    sb.delete();
    mptr = 0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    bus.req  = '0;
    bus.addr = '0;
    resetN   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.gnt !== 4'b0000 || bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 16'h0000 || rom_addr !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_values: got gnt=%b rsp_valid=%b rsp_data=%h rom_addr=%0d, want 0000 0000 0000 0",
               bus.gnt, bus.rsp_valid, bus.rsp_data, rom_addr);
    end
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [NR-1:0][CS-1:0] a;
    logic [NR-1:0] g;
    logic [CS-1:0] ra;
    logic [15:0]   rd;
    a = '0;
    a[0] = 8'd1;
    step(4'b0001, a, g, ra, rd);
    tests_run++;
    if (g !== 4'b0001 || ra !== 8'd1) begin
      tests_failed++;
      $display("FAIL single_grant: got gnt=%b rom_addr=%0d, want 0001 1", g, ra);
    end
    idle(3);
  endtask

  task automatic test_three();
    logic [NR-1:0][CS-1:0] a;
    logic [NR-1:0] g;
    logic [CS-1:0] ra;
    logic [15:0]   rd;
    logic [3:0]    rq    [3] = '{4'b0111, 4'b0110, 4'b0100};
    logic [3:0]    exp_g [3] = '{4'b0001, 4'b0010, 4'b0100};
    logic [7:0]    exp_a [3] = '{8'd0, 8'd32, 8'd64};
    do_reset();
    a = '0;
    a[0] = 8'd0;
    a[1] = 8'd32;
    a[2] = 8'd64;
    for (int c = 0; c < 3; c++) begin
      step(rq[c], a, g, ra, rd);
      tests_run++;
      if (g !== exp_g[c] || ra !== exp_a[c]) begin
        tests_failed++;
        $display("FAIL three_grant[%0d]: got gnt=%b rom_addr=%0d, want %b %0d", c, g, ra, exp_g[c], exp_a[c]);
      end
    end
    idle(3);
  endtask

  task automatic test_fairness();
    logic [NR-1:0][CS-1:0] a;
    logic [NR-1:0] g;
    logic [CS-1:0] ra;
    logic [15:0]   rd;
    logic [3:0]    eg;
    do_reset();
    for (int i = 0; i < NR; i++) rsp_seen[i] = 0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NR; i++) a[i] = 8'(8 + 4 * c + i);
      step(4'b1111, a, g, ra, rd);
      eg = 4'b0001 << (c % 4);
      tests_run++;
      if (g !== eg) begin
        tests_failed++;
        $display("FAIL fair_grant[%0d]: got gnt=%b, want %b", c, g, eg);
      end
    end
    idle(3);
    for (int i = 0; i < NR; i++) begin
      tests_run++;
      if (rsp_seen[i] !== 3) begin
        tests_failed++;
        $display("FAIL fair_count[%0d]: got %0d responses, want 3", i, rsp_seen[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [NR-1:0][CS-1:0] a;
    logic [NR-1:0] g;
    logic [CS-1:0] ra;
    logic [15:0]   rd;
    do_reset();
    a = '0;
    a[3] = 8'd5;
    step(4'b1000, a, g, ra, rd);
    tests_run++;
    if (g !== 4'b1000) begin
      tests_failed++;
      $display("FAIL wrap_first: got gnt=%b, want 1000", g);
    end
    a[0] = 8'd128;
    a[3] = 8'd7;
    step(4'b1001, a, g, ra, rd);
    tests_run++;
    if (g !== 4'b0001 || ra !== 8'd128) begin
      tests_failed++;
      $display("FAIL wrap_to_0: got gnt=%b rom_addr=%0d, want 0001 128", g, ra);
    end
    step(4'b1000, a, g, ra, rd);
    tests_run++;
    if (g !== 4'b1000 || ra !== 8'd7) begin
      tests_failed++;
      $display("FAIL wrap_then_3: got gnt=%b rom_addr=%0d, want 1000 7", g, ra);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0][CS-1:0] a;
    logic [NR-1:0] g;
    logic [CS-1:0] ra;
    logic [15:0]   rd;
    logic [7:0]    seq [4] = '{8'd1, 8'd32, 8'd64, 8'd128};
    a = '0;
    for (int c = 0; c < 4; c++) begin
      a[1] = seq[c];
      step(4'b0010, a, g, ra, rd);
      tests_run++;
      if (g !== 4'b0010 || ra !== seq[c]) begin
        tests_failed++;
        $display("FAIL b2b_grant[%0d]: got gnt=%b rom_addr=%0d, want 0010 %0d", c, g, ra, seq[c]);
      end
    end
    idle(3);
  endtask

  task automatic test_reset_midflight();
    logic [NR-1:0][CS-1:0] a;
    logic [NR-1:0] g;
    logic [CS-1:0] ra;
    logic [15:0]   rd;
    a = '0;
    a[0] = 8'd32;
    step(4'b0001, a, g, ra, rd);
    idle(3);
    a[2] = 8'd64;
    step(4'b0100, a, g, ra, rd);
    tests_run++;
    if (g !== 4'b0100) begin
      tests_failed++;
      $display("FAIL mid_grant2: got gnt=%b, want 0100", g);
    end
    bus.req  = 4'b0010;
    bus.addr = '0;
    resetN   = 1'b0;
    sb.delete();
    mptr = 0;
    @(negedge clk);
    tests_run++;
    if (bus.gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mid_gnt_in_reset: got gnt=%b, want 0000", bus.gnt);
    end
    @(posedge clk);
    #1;
    resetN  = 1'b1;
    bus.req = '0;
    @(negedge clk);
    tests_run++;
    if (bus.gnt !== 4'b0000 || bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 16'h0000 || rom_addr !== 8'd0) begin
      tests_failed++;
      $display("FAIL mid_after_reset: got gnt=%b rsp_valid=%b rsp_data=%h rom_addr=%0d, want 0000 0000 0000 0",
               bus.gnt, bus.rsp_valid, bus.rsp_data, rom_addr);
    end
    @(posedge clk);
    #1;
    a = '0;
    step(4'b1111, a, g, ra, rd);
    tests_run++;
    if (g !== 4'b0001) begin
      tests_failed++;
      $display("FAIL mid_ptr_cleared: got gnt=%b, want 0001", g);
    end
    idle(3);
  endtask

  task automatic test_idle_hold();
    logic [NR-1:0][CS-1:0] a;
    logic [NR-1:0] g;
    logic [CS-1:0] ra;
    logic [15:0]   rd;
    a = '0;
    a[0] = 8'd32;
    step(4'b0001, a, g, ra, rd);
    tests_run++;
    if (g !== 4'b0001) begin
      tests_failed++;
      $display("FAIL hold_grant: got gnt=%b, want 0001", g);
    end
    for (int k = 0; k < 5; k++) begin
      step('0, '0, g, ra, rd);
      tests_run++;
      if (g !== 4'b0000 || ra !== 8'd32) begin
        tests_failed++;
        $display("FAIL hold_addr[%0d]: got gnt=%b rom_addr=%0d, want 0000 32", k, g, ra);
      end
      if (k >= 1) begin
        tests_run++;
        if (rd !== 16'hFFB5) begin
          tests_failed++;
          $display("FAIL hold_data[%0d]: got rsp_data=%h, want ffb5", k, rd);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_three();
    test_fairness();
    test_wrap();
    test_back_to_back();
    test_reset_midflight();
    test_idle_hold();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d pending responses, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
